pc_unit: RTL and testbench

//   Parametrised program-counter unit for the CPU fetch stage.

---
 rtl/pc_unit.sv | 122 ++++++++++++
 tb/tb_pc_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: next-PC selection plus a circular
// return-address stack. All state updates on the falling clock edge.
module pc_unit #(
  parameter int              PC_W      = 32,
  parameter int              INC       = 4,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(0),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(4),
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic                         exc_valid,
  input  logic                         redirect_valid,
  input  logic                         call,
  input  logic                         ret,
  input  logic [PC_W-1:0]              redirect_target,
  output logic [PC_W-1:0]              pc,
  output logic [PC_W-1:0]              pc_plus,
  output logic [PC_W-1:0]              ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0]  INC_V = PC_W'(INC);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(RAS_DEPTH);

  // Saturating occupancy increment: a push onto a full stack keeps the count at depth.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == FULL) ? FULL : cnt + CNT_W'(1);
  endfunction

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] top_idx;
  logic             ras_empty;
  logic             ras_full;

  logic [PC_W-1:0]  pc_nxt;
  logic [PTR_W-1:0] ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;

  // ras_ptr names the next free slot; once full it also names the oldest entry.
  assign top_idx   = ras_ptr - PTR_W'(1);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == FULL);
  assign pc_plus   = pc + INC_V;
  assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];

  always_comb begin
    pc_nxt    = pc;
    ptr_nxt   = ras_ptr;
    cnt_nxt   = ras_count;
    ovf_nxt   = ras_overflow;
    unf_nxt   = ras_underflow;
    ras_we    = 1'b0;
    ras_waddr = ras_ptr;
    if (exc_valid) begin
      pc_nxt = EXC_VEC;
    end else if (ena) begin
      if (ret && call) begin
        pc_nxt = redirect_target;
        ras_we = 1'b1;
        if (ras_empty) begin
          ptr_nxt = ras_ptr + PTR_W'(1);
          cnt_nxt = CNT_W'(1);
        end else begin
          ras_waddr = top_idx;
        end
      end else if (ret) begin
        if (ras_empty) begin
          pc_nxt  = redirect_target;
          unf_nxt = 1'b1;
        end else begin
          pc_nxt  = ras_top;
          ptr_nxt = top_idx;
          cnt_nxt = ras_count - CNT_W'(1);
        end
      end else if (call) begin
        pc_nxt  = redirect_target;
        ras_we  = 1'b1;
        ptr_nxt = ras_ptr + PTR_W'(1);
        cnt_nxt = cnt_sat_inc(ras_count);
        if (ras_full) ovf_nxt = 1'b1;
      end else if (redirect_valid) begin
        pc_nxt = redirect_target;
      end else begin
        pc_nxt = pc_plus;
      end
    end
  end

  // State boundary: control state, reset asynchronously
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_VEC;
      ras_ptr       <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      ras_ptr       <= ptr_nxt;
      ras_count     <= cnt_nxt;
      ras_overflow  <= ovf_nxt;
      ras_underflow <= unf_nxt;
    end
  end

  // State boundary: return-address storage, contents meaningful only below ras_count
  always_ff @(negedge clk) begin
    if (ras_we) ras_mem[ras_waddr] <= pc_plus;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model checked every rising edge,
// plus directed sequences with hand-computed literal expectations.
module tb_pc_unit;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        exc_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [31:0] ras_top;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit dut (
    .clk(clk), .rst(rst), .ena(ena), .exc_valid(exc_valid),
    .redirect_valid(redirect_valid), .call(call), .ret(ret),
    .redirect_target(redirect_target), .pc(pc), .pc_plus(pc_plus),
    .ras_top(ras_top), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: return stack as a queue, newest entry at the back.
  logic [31:0] m_pc = '0;
  logic [31:0] m_ras[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  always @(negedge clk or negedge rst) begin
    logic [31:0] seq;
    if (!rst) begin
      m_pc = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (exc_valid) begin
      m_pc = 32'h4;
    end else if (ena) begin
      seq = m_pc + 32'd4;
      if (ret && call) begin
        if (m_ras.size() == 0) m_ras.push_back(seq);
        else m_ras[m_ras.size()-1] = seq;
        m_pc = redirect_target;
      end else if (ret) begin
        if (m_ras.size() == 0) begin
          m_pc = redirect_target;
          m_unf = 1'b1;
        end else begin
          m_pc = m_ras.pop_back();
        end
      end else if (call) begin
        if (m_ras.size() == D) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(seq);
        m_pc = redirect_target;
      end else if (redirect_valid) begin
        m_pc = redirect_target;
      end else begin
        m_pc = seq;
      end
    end
  end

  always @(posedge clk) begin
    chk("pc", pc, m_pc);
    chk("pc_plus", pc_plus, m_pc + 32'd4);
    chk("ras_top", ras_top, (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1]);
    chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
    chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    exc_valid = 1'b0; redirect_valid = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic go_to(input logic [31:0] t);
    idle();
    redirect_valid = 1'b1; redirect_target = t;
    tick();
    idle();
  endtask

  initial begin
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_count", 32'(ras_count), 32'h0);

    // Sequential advance then stall
    ena = 1'b1;
    tick(); chk("seq1", pc, 32'h4);
    tick(); chk("seq2", pc, 32'h8);
    tick(); chk("seq3", pc, 32'hC);
    ena = 1'b0;
    tick(); chk("stall1", pc, 32'hC);
    tick(); chk("stall2", pc, 32'hC);
    ena = 1'b1;

    // Call then return
    go_to(32'h100);
    chk("redir", pc, 32'h100);
    call = 1'b1; redirect_target = 32'h400;
    tick(); idle();
    chk("call_pc", pc, 32'h400);
    chk("call_top", ras_top, 32'h104);
    chk("call_cnt", 32'(ras_count), 32'h1);
    ret = 1'b1;
    tick(); idle();
    chk("ret_pc", pc, 32'h104);
    chk("ret_cnt", 32'(ras_count), 32'h0);

    // Five nested calls into a four-entry stack
    go_to(32'h10);
    for (int i = 1; i <= 5; i++) begin
      call = 1'b1;
      redirect_target = (i < 5) ? 32'((i + 1) * 16) : 32'h600;
      tick();
    end
    idle();
    chk("nest_cnt", 32'(ras_count), 32'h4);
    chk("nest_ovf", 32'(ras_overflow), 32'h1);
    chk("nest_top", ras_top, 32'h54);
    ret = 1'b1;
    tick(); chk("pop1", pc, 32'h54);
    tick(); chk("pop2", pc, 32'h44);
    tick(); chk("pop3", pc, 32'h34);
    tick(); chk("pop4", pc, 32'h24);
    idle();
    chk("pop_cnt", 32'(ras_count), 32'h0);

    // Return on empty, then exception beating stall and call
    ret = 1'b1; redirect_target = 32'h80;
    tick(); idle();
    chk("unf_pc", pc, 32'h80);
    chk("unf_flag", 32'(ras_underflow), 32'h1);
    call = 1'b1; redirect_target = 32'h90;
    tick(); idle();
    chk("call2_top", ras_top, 32'h84);
    ena = 1'b0; call = 1'b1; exc_valid = 1'b1; redirect_target = 32'h999;
    tick(); idle(); ena = 1'b1;
    chk("exc_pc", pc, 32'h4);
    chk("exc_cnt", 32'(ras_count), 32'h1);
    chk("exc_top", ras_top, 32'h84);

    // Asynchronous reset between edges
    rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_cnt", 32'(ras_count), 32'h0);
    chk("arst_ovf", 32'(ras_overflow), 32'h0);
    chk("arst_unf", 32'(ras_underflow), 32'h0);
    rst = 1'b1;

    // Wrap and simultaneous call+ret
    go_to(32'hFFFF_FFFC);
    chk("wrap_plus", pc_plus, 32'h0);
    tick(); chk("wrap_pc", pc, 32'h0);
    go_to(32'h1F0);
    call = 1'b1; redirect_target = 32'h200;
    tick(); idle();
    call = 1'b1; ret = 1'b1; redirect_target = 32'h300;
    tick(); idle();
    chk("cr_pc", pc, 32'h300);
    chk("cr_top", ras_top, 32'h204);
    chk("cr_cnt", 32'(ras_count), 32'h1);
    ret = 1'b1;
    tick(); idle();
    chk("cr_ret", pc, 32'h204);
    call = 1'b1; ret = 1'b1; redirect_target = 32'h500;
    tick(); idle();
    chk("cr_empty_pc", pc, 32'h500);
    chk("cr_empty_top", ras_top, 32'h208);
    chk("cr_empty_cnt", 32'(ras_count), 32'h1);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
